// File: rtl/layer6_ctrl_pkg.sv
// Shared constants and types for the layer6 SRAM access controller.
//   ADDR_W / DATA_W / DEPTH : default geometry of the 64x128 dual-port SRAM
//   state_t                 : controller FSM states
//   rd_sel_t                : read requester select (rd0 / rd1)
package layer6_ctrl_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR} state_t;
  typedef enum logic {RD0 = 1'b0, RD1 = 1'b1} rd_sel_t;
endpackage

// File: rtl/layer6_rr_arb.sv
// Two-way round-robin arbiter for the layer6 read requesters.
//   CK, RST_N : clock, async active-low reset
//   req[1:0]  : eligible requesters (bit 0 = rd0, bit 1 = rd1)
//   gnt[1:0]  : one-hot grant, or zero when nobody is eligible
// A lone requester always wins; on contention the pointer picks, and the
// pointer moves to the other requester after every grant.
module layer6_rr_arb
  import layer6_ctrl_pkg::*;
(
  input  logic       CK,
  input  logic       RST_N,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rd_sel_t ptr_q;

  always_comb begin
    gnt = req;
    if (&req) gnt = (ptr_q == RD0) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N)    ptr_q <= RD0;
    else if (|gnt) ptr_q <= gnt[0] ? RD1 : RD0;
  end

endmodule

// File: rtl/layer6_access_ctrl.sv
// Access sequencer for the layer6 dual-port SRAM.
// Port A carries writes from the layer-6 conv output, port B serves two read
// requesters (rd0: next-layer fetch, rd1: readback/debug). A per-entry
// written-flag scoreboard holds back reads of entries not yet written this
// frame, and same-address write/read pairs are resolved here so the SRAM
// never sees A==B with a write on A and a read on B in the same cycle.
// Ports:
//   CK, RST_N                  clock, async active-low reset
//   clr / busy                 start new frame / high during the clear cycle
//   wr_valid/ready/addr/data   write request handshake
//   rdN_req/addr/gnt           read request (held until granted) and grant
//   rdN_rvalid/data            read data, one cycle after the grant
//   wr_count / frame_full      distinct entries written this frame
//   sram_*                     SRAM wrapper interface
// Build option: LAYER6_RAW_BYPASS_EN grants a read that collides with a
// same-cycle accepted write and returns the write data from a register.
// DEPTH must equal 2**ADDR_W.
module layer6_access_ctrl
  import layer6_ctrl_pkg::*;
#(
  parameter int ADDR_W = layer6_ctrl_pkg::ADDR_W,
  parameter int DATA_W = layer6_ctrl_pkg::DATA_W,
  parameter int DEPTH  = layer6_ctrl_pkg::DEPTH
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              clr,
  output logic              busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_rvalid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rd1_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              frame_full,
  output logic [ADDR_W-1:0] sram_A,
  output logic [ADDR_W-1:0] sram_B,
  output logic              sram_WEAN,
  output logic              sram_WEBN,
  output logic              sram_OEA,
  output logic              sram_OEB,
  output logic [DATA_W-1:0] sram_DIA,
  output logic [DATA_W-1:0] sram_DIB,
  input  logic [DATA_W-1:0] sram_DOB
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;
  logic   run;

  logic [DEPTH-1:0]  sb_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] dia_q;
  logic [1:0]        rv_q;
  logic              wr_fire;

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_req, hit, elig, gnt;
  rd_sel_t                gsel;

  // ---------------- FSM ----------------
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (clr) state_d = S_CLR;
      S_CLR:   state_d = S_RUN;   // clr seen here is ignored
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run  = 1'b0;
    busy = 1'b0;
    case (state_q)
      S_RUN:   run  = 1'b1;
      S_CLR:   busy = 1'b1;
      default: ;
    endcase
  end

  // ---------------- write port (A) ----------------
  assign wr_ready  = run;
  assign wr_fire   = wr_valid & run;
  assign sram_WEAN = ~wr_fire;
  assign sram_OEA  = 1'b0;
  // Idle port keeps its last address/data so the SRAM pins stay quiet.
  assign sram_A    = wr_fire ? wr_addr : a_q;
  assign sram_DIA  = wr_fire ? wr_data : dia_q;

  // ---------------- read requesters ----------------
  assign rd_addr = {rd1_addr, rd0_addr};
  assign rd_req  = {rd1_req, rd0_req};

`ifdef LAYER6_RAW_BYPASS_EN
  // Forwarded write data for reads granted against a same-cycle write.
  logic [1:0]        byp_q;
  logic [DATA_W-1:0] wd_q;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      byp_q <= '0;
      wd_q  <= '0;
    end else begin
      byp_q <= gnt & hit;
      wd_q  <= wr_data;
    end
  end
`endif

  for (genvar n = 0; n < 2; n++) begin : g_rd
    assign hit[n] = wr_fire && (wr_addr == rd_addr[n]);
`ifdef LAYER6_RAW_BYPASS_EN
    assign elig[n]    = run && rd_req[n] && (sb_q[rd_addr[n]] || hit[n]);
    assign rd_data[n] = !rv_q[n] ? '0 : (byp_q[n] ? wd_q : sram_DOB);
`else
    // A same-address write this cycle pushes the read out by one cycle.
    assign elig[n]    = run && rd_req[n] && sb_q[rd_addr[n]] && !hit[n];
    assign rd_data[n] = rv_q[n] ? sram_DOB : '0;
`endif
  end

  layer6_rr_arb u_arb (
    .CK    (CK),
    .RST_N (RST_N),
    .req   (elig),
    .gnt   (gnt)
  );

  assign gsel = gnt[1] ? RD1 : RD0;

  // ---------------- read port (B) ----------------
  assign sram_B    = (|gnt) ? rd_addr[gsel] : b_q;
  assign sram_WEBN = 1'b1;
  assign sram_DIB  = '0;
`ifdef LAYER6_RAW_BYPASS_EN
  assign sram_OEB  = (|gnt) && !hit[gsel];
`else
  assign sram_OEB  = |gnt;
`endif

  assign rd0_gnt    = gnt[0];
  assign rd1_gnt    = gnt[1];
  assign rd0_rvalid = rv_q[0];
  assign rd1_rvalid = rv_q[1];
  assign rd0_data   = rd_data[0];
  assign rd1_data   = rd_data[1];

  assign wr_count   = cnt_q;
  assign frame_full = (cnt_q == CNT_FULL);

  // ---------------- datapath state ----------------
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      sb_q  <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dia_q <= '0;
      rv_q  <= '0;
    end else begin
      a_q   <= sram_A;
      b_q   <= sram_B;
      dia_q <= sram_DIA;
      rv_q  <= gnt;   // in-flight reads complete even across a clear
      if (state_q == S_CLR) begin
        sb_q  <= '0;
        cnt_q <= '0;
      end else if (wr_fire) begin
        sb_q[wr_addr] <= 1'b1;
        if (!sb_q[wr_addr] && (cnt_q != CNT_FULL)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer6_access_ctrl.sv
module tb_layer6_access_ctrl;
  localparam int AW  = 6;
  localparam int DW  = 128;
  localparam int DEP = 64;

  logic          CK, RST_N, clr, busy;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_req, rd1_req, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic [DW-1:0] rd0_data, rd1_data;
  logic [AW:0]   wr_count;
  logic          frame_full;
  logic [AW-1:0] sram_A, sram_B;
  logic          sram_WEAN, sram_WEBN, sram_OEA, sram_OEB;
  logic [DW-1:0] sram_DIA, sram_DIB, sram_DOB;

  layer6_access_ctrl dut (
    .CK(CK), .RST_N(RST_N), .clr(clr), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_rvalid(rd0_rvalid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_rvalid(rd1_rvalid), .rd1_data(rd1_data),
    .wr_count(wr_count), .frame_full(frame_full),
    .sram_A(sram_A), .sram_B(sram_B), .sram_WEAN(sram_WEAN), .sram_WEBN(sram_WEBN),
    .sram_OEA(sram_OEA), .sram_OEB(sram_OEB), .sram_DIA(sram_DIA), .sram_DIB(sram_DIB),
    .sram_DOB(sram_DOB)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural dual-port SRAM: registered read on port B.
  logic [DW-1:0] sram_mem [DEP];
  always @(posedge CK) begin
    if (!sram_WEAN) sram_mem[sram_A] <= sram_DIA;
    if (sram_OEB)   sram_DOB <= sram_mem[sram_B];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_CLR} mst_t;
  mst_t          mst;
  logic [DEP-1:0] written;
  logic [DW-1:0] mem [DEP];
  int            ptr;
  logic [AW-1:0] last_a, last_b;
  logic [DW-1:0] q0[$], q1[$];
  logic [1:0]    gnt_seen;
  logic          wr_seen;

  logic          m_wfire;
  logic [1:0]    m_rq, m_hit, m_ok, m_eg;
  logic [AW-1:0] m_ra [2];

  always @(negedge CK) begin
    if (!RST_N) begin
      mst = M_IDLE; written = '0; ptr = 0; last_a = '0; last_b = '0;
      q0.delete(); q1.delete(); gnt_seen = '0; wr_seen = 1'b0;
    end else begin
      m_ra[0] = rd0_addr; m_ra[1] = rd1_addr;
      m_rq    = {rd1_req, rd0_req};
      m_wfire = wr_valid && (mst == M_RUN);
      chk("wr_ready",   DW'(wr_ready),   DW'(mst == M_RUN));
      chk("busy",       DW'(busy),       DW'(mst == M_CLR));
      chk("wr_count",   DW'(wr_count),   DW'($countones(written)));
      chk("frame_full", DW'(frame_full), DW'(&written));
      chk("sram_WEAN",  DW'(sram_WEAN),  DW'(!m_wfire));
      chk("sram_WEBN",  DW'(sram_WEBN),  DW'(1'b1));
      chk("sram_A",     DW'(sram_A),     DW'(m_wfire ? wr_addr : last_a));
      if (m_wfire) chk("sram_DIA", sram_DIA, wr_data);
      for (int n = 0; n < 2; n++) begin
        m_hit[n] = m_wfire && (wr_addr == m_ra[n]);
`ifdef LAYER6_RAW_BYPASS_EN
        m_ok[n] = (mst == M_RUN) && m_rq[n] && (written[m_ra[n]] || m_hit[n]);
`else
        m_ok[n] = (mst == M_RUN) && m_rq[n] && written[m_ra[n]] && !m_hit[n];
`endif
      end
      if (m_ok == 2'b11) m_eg = (ptr == 0) ? 2'b01 : 2'b10;
      else               m_eg = m_ok;
      chk("gnt", DW'({rd1_gnt, rd0_gnt}), DW'(m_eg));
      chk("ab_collision", DW'(!sram_WEAN && sram_OEB && (sram_A == sram_B)), '0);
      gnt_seen = {rd1_gnt, rd0_gnt};
      wr_seen  = wr_valid && wr_ready;
      if (m_eg == 2'b00) begin
        chk("sram_OEB_idle", DW'(sram_OEB), '0);
        chk("sram_B_hold",   DW'(sram_B),   DW'(last_b));
      end
      for (int n = 0; n < 2; n++) begin
        if (m_eg[n]) begin
          chk("sram_B", DW'(sram_B), DW'(m_ra[n]));
`ifdef LAYER6_RAW_BYPASS_EN
          chk("sram_OEB", DW'(sram_OEB), DW'(!m_hit[n]));
`else
          chk("sram_OEB", DW'(sram_OEB), DW'(1'b1));
`endif
          if (n == 0) q0.push_back(m_hit[0] ? wr_data : mem[m_ra[0]]);
          else        q1.push_back(m_hit[1] ? wr_data : mem[m_ra[1]]);
          ptr    = 1 - n;
          last_b = m_ra[n];
        end
      end
      if (m_wfire) begin
        written[wr_addr] = 1'b1;
        mem[wr_addr]     = wr_data;
        last_a           = wr_addr;
      end
      case (mst)
        M_IDLE: mst = M_RUN;
        M_RUN:  if (clr) mst = M_CLR;
        default: begin written = '0; mst = M_RUN; end
      endcase
    end
  end

  // ---------------- read-data monitor ----------------
  logic [DW-1:0] e0, e1;
  logic          p0, p1;
  always @(posedge CK) begin
    #2;
    if (RST_N) begin
      p0 = (q0.size() != 0);
      p1 = (q1.size() != 0);
      chk("rd0_rvalid", DW'(rd0_rvalid), DW'(p0));
      chk("rd1_rvalid", DW'(rd1_rvalid), DW'(p1));
      if (p0) begin e0 = q0.pop_front(); if (rd0_rvalid) chk("rd0_data", rd0_data, e0); end
      if (p1) begin e1 = q1.pop_front(); if (rd1_rvalid) chk("rd1_data", rd1_data, e1); end
      if (!rd0_rvalid) chk("rd0_data_idle", rd0_data, '0);
      if (!rd1_rvalid) chk("rd1_data_idle", rd1_data, '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CK); #1;
    if (gnt_seen[0]) rd0_req  = 1'b0;
    if (gnt_seen[1]) rd1_req  = 1'b0;
    if (wr_seen)     wr_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 8 && wr_valid; i++) tick();
    if (wr_valid) begin timeout("write_accept"); wr_valid = 1'b0; end
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 300 && (rd0_req || rd1_req); i++) tick();
    if (rd0_req || rd1_req) begin timeout("read_grant"); rd0_req = 1'b0; rd1_req = 1'b0; end
    tick(); tick();
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int any_g;

  initial begin
    RST_N = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd0_req = 1'b0; rd1_req = 1'b0; rd0_addr = '0; rd1_addr = '0;
    repeat (3) @(posedge CK);
    #1 RST_N = 1'b1;
    chk("rst_wr_ready", DW'(wr_ready), '0);
    chk("rst_wean",     DW'(sram_WEAN), DW'(1'b1));
    chk("rst_oeb",      DW'(sram_OEB), '0);
    chk("rst_oea",      DW'(sram_OEA), '0);
    chk("rst_a",        DW'(sram_A), '0);
    chk("rst_b",        DW'(sram_B), '0);
    chk("rst_dia",      sram_DIA, '0);
    chk("rst_dib",      sram_DIB, '0);
    chk("rst_count",    DW'(wr_count), '0);
    chk("rst_rd0_data", rd0_data, '0);
    tick();

    // write 5 then read it on rd0
    wr(6'd5, {16{8'hA5}});
    chk("t1_count", DW'(wr_count), DW'(1));
    rd0_addr = 6'd5; rd0_req = 1'b1;
    tick();
    chk("t1_gnt", DW'(gnt_seen[0]), DW'(1'b1));
    tick();

    // rd1 stalls on unwritten 9 until it is written
    rd1_addr = 6'd9; rd1_req = 1'b1; any_g = 0;
    repeat (10) begin tick(); if (gnt_seen[1]) any_g++; end
    chk("t2_no_gnt", DW'(any_g), '0);
    wr_valid = 1'b1; wr_addr = 6'd9; wr_data = {8{16'h9999}};
    tick();
`ifdef LAYER6_RAW_BYPASS_EN
    chk("t2_gnt_with_write", DW'(gnt_seen[1]), DW'(1'b1));
`else
    chk("t2_gnt_with_write", DW'(gnt_seen[1]), '0);
    tick();
    chk("t2_gnt_after_write", DW'(gnt_seen[1]), DW'(1'b1));
`endif
    wait_rd();

    // both eligible: strict alternation starting with rd0
    wr(6'd20, rnd128()); wr(6'd21, rnd128());
    rd0_addr = 6'd20; rd1_addr = 6'd21;
    for (int i = 0; i < 4; i++) begin
      rd0_req = 1'b1; rd1_req = 1'b1;
      tick();
      chk("t3_alternate", DW'(gnt_seen), DW'((i % 2) ? 2'b10 : 2'b01));
    end
    wait_rd();

    // write/read collision on 12 (old 0x11, new 0x22)
    wr(6'd12, DW'(8'h11));
    wr_valid = 1'b1; wr_addr = 6'd12; wr_data = DW'(8'h22);
    rd0_addr = 6'd12; rd0_req = 1'b1;
    tick();
`ifdef LAYER6_RAW_BYPASS_EN
    chk("t4_gnt_collide", DW'(gnt_seen[0]), DW'(1'b1));
`else
    chk("t4_gnt_collide", DW'(gnt_seen[0]), '0);
    tick();
    chk("t4_gnt_next", DW'(gnt_seen[0]), DW'(1'b1));
`endif
    wait_rd();

    // fill the frame plus rewrites, then clear
    for (int a = 0; a < DEP + 3; a++) begin
      wr_valid = 1'b1; wr_addr = AW'(a % DEP); wr_data = rnd128();
      tick();
    end
    chk("t5_count_full", DW'(wr_count), DW'(DEP));
    chk("t5_frame_full", DW'(frame_full), DW'(1'b1));
    clr = 1'b1;
    tick();
    chk("t5_busy", DW'(busy), DW'(1'b1));
    chk("t5_count_in_clr", DW'(wr_count), DW'(DEP));
    tick();                         // clr still high in S_CLR: ignored
    clr = 1'b0;
    chk("t5_busy_done", DW'(busy), '0);
    chk("t5_count_zero", DW'(wr_count), '0);
    chk("t5_not_full", DW'(frame_full), '0);
    rd0_addr = 6'd0; rd0_req = 1'b1; any_g = 0;
    repeat (5) begin tick(); if (gnt_seen[0]) any_g++; end
    chk("t5_stall_after_clr", DW'(any_g), '0);
    wr(6'd0, rnd128());
    wait_rd();

    // async reset with a read in flight and a write on port A
    wr(6'd3, rnd128());
    rd0_addr = 6'd3; rd0_req = 1'b1;
    tick();
    chk("t6_gnt", DW'(gnt_seen[0]), DW'(1'b1));
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = rnd128();
    #2;
    chk("t6_rvalid_pre", DW'(rd0_rvalid), DW'(1'b1));
    chk("t6_wean_pre", DW'(sram_WEAN), '0);
    RST_N = 1'b0;
    #1;
    chk("t6_rvalid_rst", DW'(rd0_rvalid), '0);
    chk("t6_data_rst", rd0_data, '0);
    chk("t6_wean_rst", DW'(sram_WEAN), DW'(1'b1));
    chk("t6_count_rst", DW'(wr_count), '0);
    wr_valid = 1'b0; rd0_req = 1'b0;
    repeat (2) @(posedge CK);
    #1 RST_N = 1'b1;
    tick();

    // randomized traffic, small address window to provoke collisions/stalls
    for (int c = 0; c < 800; c++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = rnd128();
      clr      = ($urandom_range(0, 39) == 0);
      if (!rd0_req && $urandom_range(0, 2) == 0) begin rd0_req = 1'b1; rd0_addr = AW'($urandom_range(0, 15)); end
      if (!rd1_req && $urandom_range(0, 2) == 0) begin rd1_req = 1'b1; rd1_addr = AW'($urandom_range(0, 15)); end
      tick();
    end
    clr = 1'b0; wr_valid = 1'b0;
    tick(); tick();
    for (int a = 0; a < 16; a++) wr(AW'(a), rnd128());
    wait_rd();

    chk("q0_drained", DW'(q0.size()), '0);
    chk("q1_drained", DW'(q1.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
